// File: rtl/vc_pkg.sv
// Shared definitions for the VC demux router: pause FSM states, VC ids, class-bit position.
// Optional statistics are enabled in the top with the VC_DEMUX_STATS_EN macro.
package vc_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        PAUSED = 1'b1
    } pause_state_e;

    typedef enum logic {
        VC0 = 1'b0,
        VC1 = 1'b1
    } vc_id_e;

    localparam int DEF_BW     = 6;
    localparam int VC_SEL_BIT = DEF_BW - 1;

    // The class bit is always the MSB of the word, whatever the word width.
    function automatic int vc_sel_bit(input int bw);
        return bw - 1;
    endfunction

endpackage

// File: rtl/vc_pause_ctrl.sv
// Per-VC back-pressure generator: two-state hysteresis on VC FIFO occupancy,
// registered pause output.
module vc_pause_ctrl
    import vc_pkg::*;
#(
    parameter int CW       = 3,
    parameter int PAUSE_HI = 2,
    parameter int PAUSE_LO = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] count,
    output logic          pause
);

    localparam logic [CW-1:0] HI = CW'(PAUSE_HI);
    localparam logic [CW-1:0] LO = CW'(PAUSE_LO);

    pause_state_e state;

    // Counts strictly between LO and HI leave the state untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            pause <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (count >= HI) begin
                        state <= PAUSED;
                        pause <= 1'b1;
                    end
                end
                PAUSED: begin
                    if (count <= LO) begin
                        state <= RUN;
                        pause <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    pause <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/vc_demux_router.sv
// Captures words popped from the main FIFO, steers them to VC0/VC1 by class bit and
// drives per-VC pause back-pressure. VC_DEMUX_STATS_EN adds per-VC push counters.
module vc_demux_router
    import vc_pkg::*;
#(
    parameter int BW       = 6,
    parameter int CW       = 3,
    parameter int DEPTH    = 4,
    parameter int PAUSE_HI = 2,
    parameter int PAUSE_LO = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [BW-1:0] data_in,
    input  logic          valid_in,
    input  logic [CW-1:0] vc0_count,
    input  logic [CW-1:0] vc1_count,
    input  logic          vc0_full,
    input  logic          vc1_full,
    output logic          push_vc0,
    output logic          push_vc1,
    output logic [BW-1:0] data_vc0,
    output logic [BW-1:0] data_vc1,
    output logic          pause_vc0,
    output logic          pause_vc1,
    output logic          overflow_err
`ifdef VC_DEMUX_STATS_EN
    ,
    output logic [15:0]   vc0_words,
    output logic [15:0]   vc1_words
`endif
);

    localparam int SEL_BIT = vc_sel_bit(BW);

    // Two words can still arrive after pause rises, so HI must leave that much headroom.
    if (PAUSE_HI > DEPTH - 2 || PAUSE_LO >= PAUSE_HI) begin : g_bad_params
        $error("vc_demux_router: illegal PAUSE_HI/PAUSE_LO for DEPTH");
    end

    vc_id_e target;
    logic   accept0;
    logic   accept1;
    logic   blocked;

    assign target  = vc_id_e'(data_in[SEL_BIT]);
    assign accept0 = valid_in && (target == VC0) && !vc0_full;
    assign accept1 = valid_in && (target == VC1) && !vc1_full;
    assign blocked = valid_in && ((target == VC0) ? vc0_full : vc1_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_vc0     <= 1'b0;
            push_vc1     <= 1'b0;
            data_vc0     <= '0;
            data_vc1     <= '0;
            overflow_err <= 1'b0;
        end else begin
            push_vc0 <= accept0;
            push_vc1 <= accept1;
            if (accept0) data_vc0 <= data_in;
            if (accept1) data_vc1 <= data_in;
            if (blocked) overflow_err <= 1'b1;
        end
    end

`ifdef VC_DEMUX_STATS_EN
    // Counters track words actually written; blocked words never count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc0_words <= '0;
            vc1_words <= '0;
        end else begin
            if (accept0) vc0_words <= vc0_words + 16'd1;
            if (accept1) vc1_words <= vc1_words + 16'd1;
        end
    end
`endif

    vc_pause_ctrl #(
        .CW       (CW),
        .PAUSE_HI (PAUSE_HI),
        .PAUSE_LO (PAUSE_LO)
    ) u_pause_vc0 (
        .clk   (clk),
        .reset (reset),
        .count (vc0_count),
        .pause (pause_vc0)
    );

    vc_pause_ctrl #(
        .CW       (CW),
        .PAUSE_HI (PAUSE_HI),
        .PAUSE_LO (PAUSE_LO)
    ) u_pause_vc1 (
        .clk   (clk),
        .reset (reset),
        .count (vc1_count),
        .pause (pause_vc1)
    );

endmodule

// File: tb/tb_vc_demux_router.sv
// Bench for vc_demux_router: directed vectors, a behavioural model checked every cycle,
// and literal expectations. Statistics checks compile only with VC_DEMUX_STATS_EN.
module tb_vc_demux_router;

    localparam int HI = 2;
    localparam int LO = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic [2:0] vc0_count = '0;
    logic [2:0] vc1_count = '0;
    logic       vc0_full = 1'b0;
    logic       vc1_full = 1'b0;
    logic       push_vc0, push_vc1, pause_vc0, pause_vc1, overflow_err;
    logic [5:0] data_vc0, data_vc1;

    logic [2:0] b_count0 = '0;
    logic       b_push0, b_push1, b_pause0, b_pause1, b_ovf;
    logic [5:0] b_data0, b_data1;

`ifdef VC_DEMUX_STATS_EN
    logic [15:0] vc0_words, vc1_words, b_words0, b_words1;
`endif

    int  n_cmp = 0;
    int  n_err = 0;
    bit  cmp_en = 1'b0;

    always #5 clk = ~clk;

    vc_demux_router u_dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .vc0_count    (vc0_count),
        .vc1_count    (vc1_count),
        .vc0_full     (vc0_full),
        .vc1_full     (vc1_full),
        .push_vc0     (push_vc0),
        .push_vc1     (push_vc1),
        .data_vc0     (data_vc0),
        .data_vc1     (data_vc1),
        .pause_vc0    (pause_vc0),
        .pause_vc1    (pause_vc1),
        .overflow_err (overflow_err)
`ifdef VC_DEMUX_STATS_EN
        ,
        .vc0_words    (vc0_words),
        .vc1_words    (vc1_words)
`endif
    );

    // Second instance with a non-empty hysteresis band (HI=3, LO=1, depth 5).
    vc_demux_router #(.DEPTH(5), .PAUSE_HI(3), .PAUSE_LO(1)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (1'b0),
        .vc0_count    (b_count0),
        .vc1_count    (3'd0),
        .vc0_full     (1'b0),
        .vc1_full     (1'b0),
        .push_vc0     (b_push0),
        .push_vc1     (b_push1),
        .data_vc0     (b_data0),
        .data_vc1     (b_data1),
        .pause_vc0    (b_pause0),
        .pause_vc1    (b_pause1),
        .overflow_err (b_ovf)
`ifdef VC_DEMUX_STATS_EN
        ,
        .vc0_words    (b_words0),
        .vc1_words    (b_words1)
`endif
    );

    // Behavioural model: what each output must be after a given capture edge.
    logic        m_push0, m_push1, m_pause0, m_pause1, m_ovf;
    logic [5:0]  m_data0, m_data1;
    logic [15:0] m_w0, m_w1;

    function automatic logic next_pause(input logic cur, input logic [2:0] cnt);
        if (int'(cnt) >= HI) return 1'b1;
        if (int'(cnt) <= LO) return 1'b0;
        return cur;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_push0 = 1'b0; m_push1 = 1'b0; m_pause0 = 1'b0; m_pause1 = 1'b0;
            m_ovf = 1'b0; m_data0 = '0; m_data1 = '0; m_w0 = '0; m_w1 = '0;
        end else begin
            m_push0 = valid_in && (data_in[5] == 1'b0) && !vc0_full;
            m_push1 = valid_in && (data_in[5] == 1'b1) && !vc1_full;
            if (m_push0) begin m_data0 = data_in; m_w0 = m_w0 + 16'd1; end
            if (m_push1) begin m_data1 = data_in; m_w1 = m_w1 + 16'd1; end
            if (valid_in && (data_in[5] ? vc1_full : vc0_full)) m_ovf = 1'b1;
            m_pause0 = next_pause(m_pause0, vc0_count);
            m_pause1 = next_pause(m_pause1, vc1_count);
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en && reset) begin
            checkOutput("model push_vc0", 16'(push_vc0), 16'(m_push0));
            checkOutput("model push_vc1", 16'(push_vc1), 16'(m_push1));
            checkOutput("model data_vc0", 16'(data_vc0), 16'(m_data0));
            checkOutput("model data_vc1", 16'(data_vc1), 16'(m_data1));
            checkOutput("model pause_vc0", 16'(pause_vc0), 16'(m_pause0));
            checkOutput("model pause_vc1", 16'(pause_vc1), 16'(m_pause1));
            checkOutput("model overflow_err", 16'(overflow_err), 16'(m_ovf));
`ifdef VC_DEMUX_STATS_EN
            checkOutput("model vc0_words", vc0_words, m_w0);
            checkOutput("model vc1_words", vc1_words, m_w1);
`endif
        end
    end

    // Inputs change on a falling edge; returns on the next falling edge with outputs settled.
    task automatic applyStimulus(input logic v, input logic [5:0] d, input logic [2:0] c0,
                                 input logic [2:0] c1, input logic f0, input logic f1);
        valid_in = v; data_in = d; vc0_count = c0; vc1_count = c1;
        vc0_full = f0; vc1_full = f1;
        @(negedge clk);
    endtask

    task automatic doReset();
        valid_in = 1'b0; data_in = '0; vc0_count = '0; vc1_count = '0;
        vc0_full = 1'b0; vc1_full = 1'b0; b_count0 = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    logic [5:0] words [8];

    initial begin
        words[0] = 6'h01; words[1] = 6'h22; words[2] = 6'h03; words[3] = 6'h24;
        words[4] = 6'h05; words[5] = 6'h26; words[6] = 6'h07; words[7] = 6'h28;

        doReset();
        cmp_en = 1'b1;
        checkOutput("reset push_vc0", 16'(push_vc0), 16'h0);
        checkOutput("reset overflow_err", 16'(overflow_err), 16'h0);

        // Reset mid-stream discards the captured word immediately.
        applyStimulus(1'b1, 6'h05, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("stream push_vc0", 16'(push_vc0), 16'h1);
        checkOutput("stream data_vc0", 16'(data_vc0), 16'h05);
        data_in = 6'h25;
        @(posedge clk);
        #2;
        checkOutput("inflight push_vc1", 16'(push_vc1), 16'h1);
        reset = 1'b0;
        #1;
        checkOutput("async push_vc1", 16'(push_vc1), 16'h0);
        checkOutput("async data_vc1", 16'(data_vc1), 16'h0);
        checkOutput("async data_vc0", 16'(data_vc0), 16'h0);
        checkOutput("async push_vc0", 16'(push_vc0), 16'h0);
        valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("after reset push_vc1", 16'(push_vc1), 16'h0);

        // Steering by class bit.
        applyStimulus(1'b1, 6'h0A, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("steer push_vc0", 16'(push_vc0), 16'h1);
        checkOutput("steer data_vc0", 16'(data_vc0), 16'h0A);
        checkOutput("steer no push_vc1", 16'(push_vc1), 16'h0);
        applyStimulus(1'b1, 6'h2B, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("steer push_vc1", 16'(push_vc1), 16'h1);
        checkOutput("steer data_vc1", 16'(data_vc1), 16'h2B);
        checkOutput("steer hold data_vc0", 16'(data_vc0), 16'h0A);
        applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("idle push_vc1", 16'(push_vc1), 16'h0);

        // Hysteresis with HI=2, LO=1.
        applyStimulus(1'b0, 6'h00, 3'd1, 3'd0, 1'b0, 1'b0);
        checkOutput("hyst count1 pause", 16'(pause_vc0), 16'h0);
        applyStimulus(1'b0, 6'h00, 3'd2, 3'd0, 1'b0, 1'b0);
        checkOutput("hyst count2 pause", 16'(pause_vc0), 16'h1);
        applyStimulus(1'b0, 6'h00, 3'd1, 3'd0, 1'b0, 1'b0);
        checkOutput("hyst release pause", 16'(pause_vc0), 16'h0);
        applyStimulus(1'b0, 6'h00, 3'd0, 3'd3, 1'b0, 1'b0);
        checkOutput("hyst pause_vc1", 16'(pause_vc1), 16'h1);
        applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 1'b0, 1'b0);

        // Hysteresis band HI=3, LO=1 on the second instance: 3 -> 2 -> 3 -> 1.
        b_count0 = 3'd2; @(negedge clk);
        checkOutput("band count2 from run", 16'(b_pause0), 16'h0);
        b_count0 = 3'd3; @(negedge clk);
        checkOutput("band count3", 16'(b_pause0), 16'h1);
        b_count0 = 3'd2; @(negedge clk);
        checkOutput("band count2 holds", 16'(b_pause0), 16'h1);
        b_count0 = 3'd3; @(negedge clk);
        checkOutput("band count3 again", 16'(b_pause0), 16'h1);
        b_count0 = 3'd1; @(negedge clk);
        checkOutput("band release", 16'(b_pause0), 16'h0);
        b_count0 = 3'd0;

        // Overflow is sticky.
        applyStimulus(1'b1, 6'h3F, 3'd0, 3'd0, 1'b0, 1'b1);
        checkOutput("ovf push_vc1", 16'(push_vc1), 16'h0);
        checkOutput("ovf flag", 16'(overflow_err), 16'h1);
        checkOutput("ovf data held", 16'(data_vc1), 16'h2B);
        applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("ovf sticky", 16'(overflow_err), 16'h1);

        // Alternating classes with idle gaps; word 2 pushes while count crosses HI.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, words[i], (i == 2) ? 3'd2 : 3'd0, 3'd0, 1'b0, 1'b0);
            if (i == 2) begin
                checkOutput("simul push_vc0", 16'(push_vc0), 16'h1);
                checkOutput("simul pause_vc0", 16'(pause_vc0), 16'h1);
            end
            if (i % 2 == 1) begin
                applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 1'b0, 1'b0);
                checkOutput("gap push_vc0", 16'(push_vc0), 16'h0);
                checkOutput("gap push_vc1", 16'(push_vc1), 16'h0);
            end
        end
        checkOutput("b2b last data_vc1", 16'(data_vc1), 16'h28);
        checkOutput("b2b last data_vc0", 16'(data_vc0), 16'h07);

        checkOutput("inst b push_vc0", 16'(b_push0), 16'h0);
        checkOutput("inst b push_vc1", 16'(b_push1), 16'h0);
        checkOutput("inst b data_vc0", 16'(b_data0), 16'h0);
        checkOutput("inst b data_vc1", 16'(b_data1), 16'h0);
        checkOutput("inst b pause_vc1", 16'(b_pause1), 16'h0);
        checkOutput("inst b overflow", 16'(b_ovf), 16'h0);

`ifdef VC_DEMUX_STATS_EN
        doReset();
        checkOutput("stats reset vc0", vc0_words, 16'h0000);
        for (int k = 0; k < 65534; k++) begin
            applyStimulus(1'b1, 6'h11, 3'd0, 3'd0, 1'b0, 1'b0);
        end
        checkOutput("stats preload vc0", vc0_words, 16'hFFFE);
        applyStimulus(1'b1, 6'h11, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("stats max vc0", vc0_words, 16'hFFFF);
        applyStimulus(1'b1, 6'h11, 3'd0, 3'd0, 1'b0, 1'b0);
        checkOutput("stats wrap vc0", vc0_words, 16'h0000);
        checkOutput("stats vc1 untouched", vc1_words, 16'h0000);
        applyStimulus(1'b1, 6'h31, 3'd0, 3'd0, 1'b0, 1'b1);
        checkOutput("stats blocked not counted", vc1_words, 16'h0000);
        checkOutput("inst b words0", b_words0, 16'h0000);
        checkOutput("inst b words1", b_words1, 16'h0000);
`endif

        applyStimulus(1'b0, 6'h00, 3'd0, 3'd0, 1'b0, 1'b0);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
